updown_counter_cmd: RTL and testbench
=====================================

// Module: updown_counter_cmd
// PURPOSE
//  Command-driven up/down counter: the control-side producer of the load/updown/count
//  interface that the counter checker observes. Accepts LOAD/UP/DOWN commands over a
//  valid/ready port and drives registered load/updown/enable strobes plus the count itself.
//  Sits between the test/control logic and any logic consuming count.
// PARAMETERS
//  WIDTH   4  count and load-data width; count is modulo 2**WIDTH
//  LEN_W   4  step-length field width; one command performs cmd_len+1 steps
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  cmd_valid  in   1      command valid
//  cmd_ready  out  1      command accepted on a clk edge where cmd_valid & cmd_ready
//  cmd_op     in   2      00 NOP, 01 LOAD, 10 UP, 11 DOWN
//  cmd_data   in   WIDTH  load value, LOAD only
//  cmd_len    in   LEN_W  step count minus 1, UP/DOWN only
//  abort      in   1      cancel the in-progress command
//  load       out  1      registered: count takes data at the next edge
//  updown     out  1      registered direction, 1 = up; holds its last value when idle
//  en         out  1      registered: count steps at the next edge
//  data       out  WIDTH  registered load value, valid while load = 1
//  count      out  WIDTH  counter value
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: command completed, count is final
//  wrap       out  1      one-cycle pulse in the cycle count first shows a wrapped value
// BEHAVIOUR
//  Reset (rst_n = 0, immediate, including mid-command):
//   - state = IDLE; count, load, updown, en, data, busy, done and wrap all go to 0.
//   - cmd_ready = 1.
//  FSM states: IDLE, LOAD, RUN.
//   - cmd_ready = (state == IDLE), combinational.
//  IDLE, accept at edge A:
//   - LOAD: enter LOAD; load = 1 and data = cmd_data in cycle A+1.
//   - UP/DOWN: enter RUN; en = 1 and updown = op[0] ^ 1; rem = cmd_len.
//   - NOP: accepted; no state change, no done.
//  LOAD (one cycle): at the next edge, count <= data and state -> IDLE.
//  RUN:
//   - At every edge, count <= count +/- 1 (modulo 2**WIDTH).
//   - If rem == 0, state -> IDLE and en -> 0; otherwise rem decrements.
//   - en stays high for exactly cmd_len+1 consecutive cycles.
//  Update rule: count changes only at an edge that closes a cycle with load = 1 (to data)
//   or en = 1 (step). Otherwise count holds. load and en are never both 1.
//  Latency:
//   - LOAD: count = cmd_data and done = 1 in cycle A+2.
//   - UP/DOWN: final count and done = 1 in cycle A+cmd_len+2.
//   - A new command may be accepted in the done cycle.
//  wrap:
//   - Set when a step takes 2**WIDTH-1 -> 0 (up) or 0 -> 2**WIDTH-1 (down).
//   - A LOAD never sets wrap.
//  abort (sampled only in LOAD or RUN):
//   - The current cycle's strobe still takes effect at the edge.
//   - State -> IDLE and load/en -> 0 at that edge; no done pulse.
//   - abort in IDLE is ignored. abort and accept cannot coincide.
//  cmd_* inputs are don't-care unless cmd_valid & cmd_ready.
// TESTING
//  1 LOAD 4'hA at edge A -> load=1, data=A in A+1; count=A, done=1, cmd_ready=1 in A+2
//  2 count=E, UP len=2 -> en high 3 cycles; count E,F,0,1; wrap=1 with count=0; done with count=1
//  3 count=0, DOWN len=0 -> en high 1 cycle, updown=0; next cycle count=F, wrap=1, done=1
//  4 UP len=15 from 3, abort on 3rd en cycle -> count=6, busy=0, done never pulses
//  5 cmd_valid held across LOAD 5, DOWN len=1, UP len=0 -> each accepted only in IDLE; count 5,4,3,4
//  6 rst_n=0 mid-RUN with count=7 -> count=0, en=0, busy=0, cmd_ready=1 before the next edge

Source files
------------

// File: rtl/updown_counter_cmd.sv
// ---------------------------------------------------------------------------
// updown_counter_cmd
//   Command-driven up/down counter. LOAD/UP/DOWN commands arrive over a
//   valid/ready port. The block drives registered load/updown/en strobes and
//   the count they act on. Each strobe takes effect at the edge that closes
//   the cycle in which it is high.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command valid
//   cmd_ready  out  high while idle; a command is accepted on valid & ready
//   cmd_op     in   00 NOP, 01 LOAD, 10 UP, 11 DOWN
//   cmd_data   in   load value (LOAD only)
//   cmd_len    in   number of steps minus one (UP/DOWN only)
//   abort      in   cancel the in-progress command (ignored when idle)
//   load       out  count takes data at the next edge
//   updown     out  step direction, 1 = up; holds its last value when idle
//   en         out  count steps at the next edge
//   data       out  load value, valid while load = 1
//   count      out  counter value, modulo 2**WIDTH
//   busy       out  a command is in progress
//   done       out  one-cycle pulse: command completed, count is final
//   wrap       out  one-cycle pulse in the first cycle count shows a wrapped value
// ---------------------------------------------------------------------------
module updown_counter_cmd #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             load,
  output logic             updown,
  output logic             en,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b01;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] rem;
  logic             accept;
  logic             accept_load;
  logic             accept_step;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign accept_load = accept & (cmd_op == OP_LOAD);
  // UP and DOWN are the two ops with the high bit set.
  assign accept_step = accept & cmd_op[1];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept_load)      state_next = S_LOAD;
        else if (accept_step) state_next = S_RUN;
      end
      S_LOAD:  state_next = S_IDLE;
      S_RUN:   if (abort || rem == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and strobes. load/en are only ever high in LOAD/RUN
  // respectively, so the count update below keys off the strobes themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      load   <= 1'b0;
      updown <= 1'b0;
      en     <= 1'b0;
      data   <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;

      if (load) begin
        count <= data;
      end else if (en) begin
        if (updown) begin
          count <= count + WIDTH'(1);
          wrap  <= (count == '1);
        end else begin
          count <= count - WIDTH'(1);
          wrap  <= (count == '0);
        end
      end

      unique case (state)
        S_IDLE: begin
          if (accept_load) begin
            load <= 1'b1;
            data <= cmd_data;
          end else if (accept_step) begin
            en     <= 1'b1;
            updown <= ~cmd_op[0];
            rem    <= cmd_len;
          end
        end
        S_LOAD: begin
          load <= 1'b0;
          done <= ~abort;
        end
        S_RUN: begin
          if (abort) begin
            en <= 1'b0;
          end else if (rem == '0) begin
            en   <= 1'b0;
            done <= 1'b1;
          end else begin
            rem <= rem - LEN_W'(1);
          end
        end
        default: begin
          load <= 1'b0;
          en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_counter_cmd.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_cmd
//   Directed bench for updown_counter_cmd (WIDTH = 4, LEN_W = 4). Inputs are
//   driven and outputs sampled 1 ns after each rising edge. Expected values
//   are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_updown_counter_cmd;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_len;
  logic       abort;
  logic       load;
  logic       updown;
  logic       en;
  logic [3:0] data;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  updown_counter_cmd #(.WIDTH(4), .LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .load      (load),
    .updown    (updown),
    .en        (en),
    .data      (data),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge; returns in cycle A+1.
  task automatic cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Hold cmd_valid until the command is accepted; reports count in the
  // accepting cycle. cmd_valid is left high for back-to-back issue.
  task automatic send_held(input logic [1:0] op, input logic [3:0] d, input logic [3:0] len,
                           output logic [3:0] cnt_at_accept);
    bit got = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    cnt_at_accept = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      if (cmd_ready) begin
        cnt_at_accept = count;
        got = 1'b1;
      end
      tick();
    end
    if (!got) check("held_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (done) seen = 1'b1;
      else      tick();
    end
    check("wait_done", 32'(seen), 1);
  endtask

  logic [3:0] c_load5, c_down, c_up;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    cmd_len   = '0;
    abort     = 1'b0;

    // Reset state
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_strb",  {28'd0, load, en, done, wrap}, 0);
    check("rst_updown", 32'(updown), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // NOP: accepted, nothing happens
    cmd(OP_NOP, 4'h9, 4'h3);
    check("nop_busy",  32'(busy), 0);
    check("nop_done",  32'(done), 0);
    check("nop_count", 32'(count), 0);

    // 1: LOAD A
    cmd(OP_LOAD, 4'hA, 4'h0);
    check("t1_load",  32'(load), 1);
    check("t1_data",  32'(data), 32'hA);
    check("t1_ready", 32'(cmd_ready), 0);
    check("t1_count_a1", 32'(count), 0);
    tick();
    check("t1_count", 32'(count), 32'hA);
    check("t1_done",  32'(done), 1);
    check("t1_rdy2",  32'(cmd_ready), 1);
    check("t1_wrap",  32'(wrap), 0);

    // 2: from E, UP len 2 issued in the done cycle of the load
    cmd(OP_LOAD, 4'hE, 4'h0);
    tick();
    check("t2_pre", 32'(count), 32'hE);
    cmd(OP_UP, 4'h0, 4'd2);
    check("t2_en0", 32'(en), 1);
    check("t2_dir", 32'(updown), 1);
    check("t2_c0",  32'(count), 32'hE);
    tick();
    check("t2_en1", 32'(en), 1);
    check("t2_c1",  32'(count), 32'hF);
    check("t2_w1",  32'(wrap), 0);
    tick();
    check("t2_en2", 32'(en), 1);
    check("t2_c2",  32'(count), 32'h0);
    check("t2_w2",  32'(wrap), 1);
    check("t2_d2",  32'(done), 0);
    tick();
    check("t2_en3", 32'(en), 0);
    check("t2_c3",  32'(count), 32'h1);
    check("t2_done", 32'(done), 1);
    check("t2_w3",  32'(wrap), 0);

    // 3: from 0, DOWN len 0
    cmd(OP_LOAD, 4'h0, 4'h0);
    tick();
    check("t3_load_nowrap", 32'(wrap), 0);
    cmd(OP_DOWN, 4'h0, 4'd0);
    check("t3_en",  32'(en), 1);
    check("t3_dir", 32'(updown), 0);
    tick();
    check("t3_count", 32'(count), 32'hF);
    check("t3_wrap",  32'(wrap), 1);
    check("t3_done",  32'(done), 1);
    check("t3_en_off", 32'(en), 0);
    tick();
    check("t3_wrap_pulse", 32'(wrap), 0);
    check("t3_dir_hold", 32'(updown), 0);

    // 4: UP len 15 from 3, abort in the 3rd en cycle
    cmd(OP_LOAD, 4'h3, 4'h0);
    tick();
    cmd(OP_UP, 4'h0, 4'd15);
    check("t4_c1", 32'(count), 3);
    tick();
    check("t4_c2", 32'(count), 4);
    tick();
    check("t4_c3", 32'(count), 5);
    check("t4_en3", 32'(en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_count", 32'(count), 6);
    check("t4_busy",  32'(busy), 0);
    check("t4_en",    32'(en), 0);
    check("t4_done",  32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_done_later", 32'(done), 0);
      check("t4_hold", 32'(count), 6);
    end

    // abort in IDLE is ignored; the following command still runs normally
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_count", 32'(count), 6);

    // 5: cmd_valid held across three commands
    send_held(OP_LOAD, 4'h5, 4'h0, c_load5);
    send_held(OP_DOWN, 4'h0, 4'd1, c_down);
    send_held(OP_UP,   4'h0, 4'd0, c_up);
    cmd_valid = 1'b0;
    check("t5_load_acc", 32'(c_load5), 6);
    check("t5_down_acc", 32'(c_down), 5);
    check("t5_up_acc",   32'(c_up), 3);
    wait_done(10);
    check("t5_final", 32'(count), 4);

    // 6: asynchronous reset mid-RUN at count 7
    tick();
    cmd(OP_LOAD, 4'h5, 4'h0);
    tick();
    cmd(OP_UP, 4'h0, 4'd10);
    tick();
    tick();
    check("t6_pre", 32'(count), 7);
    check("t6_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_count", 32'(count), 0);
    check("t6_en",    32'(en), 0);
    check("t6_busy",  32'(busy), 0);
    check("t6_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_after", 32'(count), 0);
    check("t6_idle",  32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
